controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 70 +++++++
 tb/tb_controller.sv | 115 +++++++++++
 2 files changed

// File: rtl/controller.sv
// rtl/controller.sv - PI controller on two +/-1 bitstreams; CONTROLLER_SAT_EN selects saturating over wrapping arithmetic
module controller #(
    parameter int WIDTH    = 24,
    parameter int KP_SHIFT = 4,
    parameter int KI_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in,
    input  logic                    fbin,
    output logic signed [WIDTH-1:0] out
);

    logic signed [2:0]       err;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] out_q, out_d;

    // A set bit encodes -1, so in=0/fbin=1 is +1 - (-1) = +2.
    always_comb begin
        err = 3'sd0;
        case ({in, fbin})
            2'b01:   err = 3'sd2;
            2'b10:   err = -3'sd2;
            default: err = 3'sd0;
        endcase
    end

`ifdef CONTROLLER_SAT_EN
    localparam int EW = WIDTH + 2;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [EW-1:0] acc_sum, out_sum;

    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [EW-1:0] v);
        if (v > EW'(SAT_MAX))
            return SAT_MAX;
        else if (v < EW'(SAT_MIN))
            return SAT_MIN;
        else
            return v[WIDTH-1:0];
    endfunction

    always_comb begin
        acc_sum = EW'(acc_q) + (EW'(err) <<< KI_SHIFT);
        acc_d   = clamp(acc_sum);
        out_sum = EW'(acc_d) + (EW'(err) <<< KP_SHIFT);
        out_d   = clamp(out_sum);
    end
`else
    // Wrapping: the low WIDTH bits of a wider sum equal the WIDTH-bit sum.
    always_comb begin
        acc_d = acc_q + (WIDTH'(err) <<< KI_SHIFT);
        out_d = acc_d + (WIDTH'(err) <<< KP_SHIFT);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed checks of controller at default width and an 8-bit overflow instance
module tb_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, in = 1'b0, fbin = 1'b0;
    logic signed [23:0] out_w;

    logic rst_s = 1'b1, in_s = 1'b0, fbin_s = 1'b0;
    logic signed [7:0] out_s;

    int n_cmp = 0;
    int n_bad = 0;

    controller dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .fbin (fbin),
        .out  (out_w)
    );

    controller #(.WIDTH(8)) dut_s (
        .clk  (clk),
        .rst  (rst_s),
        .in   (in_s),
        .fbin (fbin_s),
        .out  (out_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic i, input logic f);
        rst = r; in = i; fbin = f;
        @(posedge clk);
        #1;
    endtask

    task automatic step_s(input logic r, input logic i, input logic f);
        rst_s = r; in_s = i; fbin_s = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Default-width instance
        step(1'b1, 1'b1, 1'b0);
        check("reset", int'(out_w), 0);

        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("matched0_%0d", k), int'(out_w), 0);
        end
        step(1'b0, 1'b1, 1'b1);
        check("matched1", int'(out_w), 0);

        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("pos_%0d", k), int'(out_w), 2 * k + 32);
        end
        step(1'b1, 1'b0, 1'b1);
        check("midrun_reset", int'(out_w), 0);
        step(1'b0, 1'b0, 1'b1);
        check("after_reset", int'(out_w), 34);

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("neg_one", int'(out_w), -34);
        check("neg_hex", int'(out_w[23:0] == 24'hFFFFDE), 1);
        step(1'b0, 1'b1, 1'b1);
        check("hold_acc", int'(out_w), -2);
        step(1'b0, 1'b0, 1'b1);
        check("acc_back", int'(out_w), 32);

        // 8-bit instance: range -128..127, out offset by +/-32
        step_s(1'b1, 1'b0, 1'b1);
        check("s_reset", int'(out_s), 0);
        for (int k = 1; k <= 63; k++) begin
            step_s(1'b0, 1'b0, 1'b1);
            if (k == 40) check("s_pre40", int'(out_s), 112);
        end
`ifdef CONTROLLER_SAT_EN
        check("s_edge63", int'(out_s), 127);
        step_s(1'b0, 1'b0, 1'b1);
        check("s_edge64", int'(out_s), 127);
        step_s(1'b0, 1'b0, 1'b1);
        check("s_edge65", int'(out_s), 127);
        step_s(1'b0, 1'b0, 1'b0);
        check("s_acc_lim", int'(out_s), 127);
        step_s(1'b0, 1'b1, 1'b0);
        check("s_reverse", int'(out_s), 93);
`else
        check("s_edge63", int'(out_s), -98);
        step_s(1'b0, 1'b0, 1'b1);
        check("s_edge64", int'(out_s), -96);
        step_s(1'b0, 1'b0, 1'b1);
        check("s_edge65", int'(out_s), -94);
        step_s(1'b0, 1'b0, 1'b0);
        check("s_acc_wrap", int'(out_s), -126);
        step_s(1'b0, 1'b1, 1'b0);
        check("s_reverse", int'(out_s), 96);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
